// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bundle
// for the multi-cycle divider.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: non-restoring divider, one quotient bit per clock,
// then one correction/sign-fix cycle. Signed, unsigned, div-by-zero.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    seq_divider_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mr;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zflag;

    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH:0]   acc_fix;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    // Operand magnitudes, the next non-restoring step, and final sign fix.
    always_comb begin
        dvd_neg  = bus.signed_mode & bus.dividend[WIDTH-1];
        dvs_neg  = bus.signed_mode & bus.divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
        shifted  = {acc[WIDTH-1:0], qr[WIDTH-1]};
        acc_step = acc[WIDTH] ? shifted + {1'b0, mr}
                              : shifted - {1'b0, mr};
        acc_fix  = acc[WIDTH] ? acc + {1'b0, mr} : acc;
        quo_fin  = neg_q ? -qr : qr;
        rem_fin  = neg_r ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];
    end

    // Control FSM and datapath registers; the zero path keeps the raw
    // dividend in qr so it can be returned as the remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            qr     <= '0;
            mr     <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            zflag  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        neg_q  <= dvd_neg ^ dvs_neg;
                        neg_r  <= dvd_neg;
                        mr     <= dvs_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        if (bus.divisor == '0) begin
                            zflag <= 1'b1;
                            qr    <= bus.dividend;
                            state <= S_FIX;
                        end else begin
                            zflag <= 1'b0;
                            qr    <= dvd_mag;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    qr  <= {qr[WIDTH-2:0], ~acc_step[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    dz_r   <= zflag;
                    if (zflag) begin
                        quo_r <= '1;
                        rem_r <= qr;
                    end else begin
                        quo_r <= quo_fin;
                        rem_r <= rem_fin;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised, multi-cycle integer divider with a start/done handshake, selectable signed or unsigned operation and divide-by-zero reporting. It generates one quotient bit per clock using non-restoring division, followed by a single correction cycle. It replaces a purely combinational divide in the datapath's multiply/divide unit. It lets the divide path close timing at WIDTH=32 and gives the controller a clean busy/done interface.

## Interface

- WIDTH, 32, operand and result width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  request a divide; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- busy  out  1  high while a divide is in progress.
- done  out  1  one-cycle pulse when quotient/remainder are valid.
- quotient  out  WIDTH  result; held until the next done.
- remainder  out  WIDTH  result; held until the next done.
- div_by_zero  out  1  set with done when divisor was 0; held until the next done.

## Operation

- States: IDLE, RUN, FIX.
- IDLE, capture edge (start=1):
  - Latch signed_mode, the operand signs, and the magnitudes |dividend| and |divisor|; magnitudes are the raw operands when unsigned.
  - Clear the WIDTH+1-bit partial remainder A and the iteration counter.
  - If divisor==0, go to FIX with the zero flag set; otherwise go to RUN. busy=1.
- RUN: one non-restoring step per cycle.
  - Shift {A,Q} left by 1.
  - If A was non-negative before the shift, A -= {0,M}; otherwise A += {0,M}.
  - Q[0] = ~A[WIDTH].
  - After WIDTH steps, go to FIX.
- FIX, single cycle:
  - If A is negative, A += M.
  - Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Register quotient, remainder and div_by_zero; done=1, busy=0; return to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend unchanged (both modes), div_by_zero=1.
- Signed overflow, (-2^(WIDTH-1)) / -1: quotient = -2^(WIDTH-1) (wraps), remainder = 0, div_by_zero=0.
- start while busy is ignored; it is not queued.
- Operand and mode inputs may change freely after the capture edge.
- start held high continuously: a new divide is captured in the IDLE cycle that immediately follows done, i.e. while done is high.

## Timing

- Reset values:
  - State = IDLE.
  - busy = 0, done = 0, div_by_zero = 0.
  - quotient = 0, remainder = 0.
- reset mid-operation aborts the divide on that edge: no done pulse, outputs return to their reset values.
- reset has priority over start on the same edge.
- Normal latency:
  - Capture edge E0; RUN steps on edges E1..E_WIDTH; FIX on edge E_(WIDTH+1).
  - done is high during the cycle after E_(WIDTH+1): WIDTH+2 edges including capture (34 at WIDTH=32).
- Divide-by-zero latency: FIX on E1, so done is high in the cycle after E1.
- busy is high in every cycle from after E0 through the FIX cycle, and low in the cycle in which done is high.
- done and busy are never high together.
- Maximum issue rate: one divide per WIDTH+2 cycles.
- All outputs are registered; no combinational path from any input to any output.

## Test plan

- WIDTH=32, unsigned 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 34 edges after the capture edge, busy high for the preceding 33 cycles.
- Signed -100/7 (0xFFFFFF9C / 0x00000007) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Same operands unsigned -> quotient=0x24924916, remainder=0x00000002.
- Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- 5/0 in both modes -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done 2 edges after capture. A following 9/3 -> div_by_zero cleared, quotient=3, remainder=0.
- start pulsed at cycle 10 of a divide with different operands -> ignored; the first result is unchanged and no second done appears. start held high continuously -> back-to-back done pulses every 34 cycles.
- reset asserted at cycle 20 of a divide -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse follows. A fresh start then completes normally.
